// File: rtl/paint_scanner_if.sv
// Paint-scanner bus: read port toward the shared paint RAM and pixel port toward the VGA adapter.
// The master side is the scanner; the slave side is the RAM/VGA environment.
interface paint_scanner_if;
    logic [14:0] ram_address;
    logic [2:0]  ram_q;
    logic        ram_busy;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    modport master (
        output ram_address,
        output x,
        output y,
        output colour,
        output plot,
        input  ram_q,
        input  ram_busy
    );

    modport slave (
        input  ram_address,
        input  x,
        input  y,
        input  colour,
        input  plot,
        output ram_q,
        output ram_busy
    );
endinterface

// File: rtl/paint_scanner.sv
// Raster-scans the paint RAM and replays every tile as a VGA pixel write, yielding to the writer.
// Optional SCAN_OVERLAY_EN: tiles under a player head are plotted white (3'b111).
module paint_scanner #(
    parameter int unsigned X_LAST = 159,
    parameter int unsigned Y_LAST = 119,
    parameter int unsigned RD_LAT = 2     // must be >= 2: RAM address register + output sample
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [14:0]            p1,
    input  logic [14:0]            p2,
    input  logic [14:0]            p3,
    input  logic [14:0]            p4,
    paint_scanner_if.master        bus,
    output logic                   frame_done
);

    localparam logic [7:0]  XLast  = 8'(X_LAST);
    localparam logic [6:0]  YLast  = 7'(Y_LAST);
    localparam int unsigned Depth  = RD_LAT - 1;
    localparam int unsigned DrainW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
`ifdef SCAN_OVERLAY_EN
        logic       hit;
`endif
    } slot_t;

    state_e            r_state, w_state_next;
    logic [7:0]        r_cx, w_cx_next;
    logic [6:0]        r_cy, w_cy_next;
    logic [DrainW-1:0] r_drain, w_drain_next;
    logic              w_issue;
    logic              w_last_pix;
    slot_t             w_slot;
    slot_t             r_pipe [Depth];
    slot_t             w_tail;
    logic [7:0]        r_x;
    logic [6:0]        r_y;
    logic [2:0]        r_colour;
    logic              r_plot;

    // A read issued while the writer owns the RAM returns the writer's data, so it is void.
    assign w_issue    = (r_state == StScan) && !bus.ram_busy;
    assign w_last_pix = (r_cx == XLast) && (r_cy == YLast);

    always_comb begin
        w_state_next = r_state;
        w_cx_next    = r_cx;
        w_cy_next    = r_cy;
        w_drain_next = r_drain;
        unique case (r_state)
            StIdle: begin
                w_cx_next = '0;
                w_cy_next = '0;
                if (enable) begin
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (w_issue) begin
                    if (w_last_pix) begin
                        w_cx_next    = '0;
                        w_cy_next    = '0;
                        w_drain_next = '0;
                        w_state_next = StDrain;
                    end else if (r_cx == XLast) begin
                        w_cx_next = '0;
                        w_cy_next = r_cy + 7'd1;
                    end else begin
                        w_cx_next = r_cx + 8'd1;
                    end
                end
            end
            StDrain: begin
                if (r_drain == DrainLast) begin
                    w_drain_next = '0;
                    w_state_next = StDone;
                end else begin
                    w_drain_next = r_drain + 1'b1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_cx    <= '0;
            r_cy    <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_next;
            r_cx    <= w_cx_next;
            r_cy    <= w_cy_next;
            r_drain <= w_drain_next;
        end
    end

    always_comb begin
        w_slot       = '0;
        w_slot.valid = w_issue;
        w_slot.x     = r_cx;
        w_slot.y     = r_cy;
`ifdef SCAN_OVERLAY_EN
        w_slot.hit   = ({r_cx, r_cy} == p1) || ({r_cx, r_cy} == p2) ||
                       ({r_cx, r_cy} == p3) || ({r_cx, r_cy} == p4);
`endif
    end

`ifndef SCAN_OVERLAY_EN
    logic w_unused_p;
    assign w_unused_p = ^{p1, p2, p3, p4};
`endif

    // Slot stages line up with the RAM latency; the output registers form the final stage.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < Depth; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_slot;
            for (int i = 1; i < Depth; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail = r_pipe[Depth-1];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= w_tail.valid;
            if (w_tail.valid) begin
                r_x <= w_tail.x;
                r_y <= w_tail.y;
`ifdef SCAN_OVERLAY_EN
                r_colour <= w_tail.hit ? 3'b111 : bus.ram_q;
`else
                r_colour <= bus.ram_q;
`endif
            end
        end
    end

    assign bus.ram_address = {r_cx, r_cy};
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.colour      = r_colour;
    assign bus.plot        = r_plot;
    assign frame_done      = (r_state == StDone);

endmodule
